// File: rtl/mmio_pkg.sv
// Shared MMIO definitions: peripheral address map and UART transmitter state encoding.
package mmio_pkg;

    localparam logic [31:0] TX_ADDR_DEFAULT  = 32'h0000_1000;
    localparam logic [31:0] CLR_ADDR_DEFAULT = 32'h0000_1004;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter; head is presented combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];

    // Storage array; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (push_ok_s && !pop_ok_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_ok_s && !push_ok_s) begin
                count_r <= count_r - CW'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-snooping UART transmitter: queues byte stores to TX_ADDR and sends them as 8N1 frames.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = TX_ADDR_DEFAULT,
    parameter logic [31:0] CLR_ADDR     = CLR_ADDR_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   value_from_alu,
    input  logic [31:0]                   data_to_write,
    input  logic                          writting_to_mem,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_t       state_r;
    logic              tx_r;
    logic              overflow_r;
    logic [BAUD_W-1:0] baud_r;
    logic [2:0]        bit_idx_r;
    logic [7:0]        shift_r;

    logic              push_s;
    logic              clr_s;
    logic              pop_s;
    logic              drop_s;
    logic [7:0]        fifo_dout_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              unused_data_s;

    assign unused_data_s = ^data_to_write[31:8];

    assign push_s = writting_to_mem && (value_from_alu == TX_ADDR);
    assign clr_s  = writting_to_mem && (value_from_alu == CLR_ADDR);
    assign pop_s  = (state_r == IDLE) && !fifo_empty_s;
    assign drop_s = push_s && fifo_full_s && !pop_s;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (data_to_write[7:0]),
        .dout  (fifo_dout_s),
        .count (fifo_count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_s) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Frame FSM with baud counter, bit index, shift register and registered line output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            tx_r      <= 1'b1;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        shift_r   <= fifo_dout_s;
                        baud_r    <= {BAUD_W{1'b0}};
                        bit_idx_r <= 3'd0;
                        tx_r      <= 1'b0;
                        state_r   <= START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                START: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r  <= {BAUD_W{1'b0}};
                        tx_r    <= shift_r[0];
                        state_r <= DATA;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r  <= {BAUD_W{1'b0}};
                        shift_r <= {1'b0, shift_r[7:1]};
                        // Look one bit ahead so the line changes on the same edge as the shift.
                        if (bit_idx_r == 3'd7) begin
                            bit_idx_r <= 3'd0;
                            tx_r      <= 1'b1;
                            state_r   <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r  <= {BAUD_W{1'b0}};
                        tx_r    <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign tx       = tx_r;
    assign overflow = overflow_r;
    assign busy     = (state_r != IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised and directed bench for mmio_uart_tx against a frame-timeline reference model.
module tb_mmio_uart_tx;

    localparam int          C        = 4;
    localparam int          D        = 4;
    localparam logic [31:0] TX_ADDR  = 32'h0000_1000;
    localparam logic [31:0] CLR_ADDR = 32'h0000_1004;

    logic        clk;
    logic        reset;
    logic [31:0] value_from_alu;
    logic [31:0] data_to_write;
    logic        writting_to_mem;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of pending bytes plus position inside the current frame.
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    bit         m_act;
    int         m_k;
    bit         m_ovf;

    mmio_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D),
        .TX_ADDR      (TX_ADDR),
        .CLR_ADDR     (CLR_ADDR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .value_from_alu  (value_from_alu),
        .data_to_write   (data_to_write),
        .writting_to_mem (writting_to_mem),
        .tx              (tx),
        .busy            (busy),
        .fifo_count      (fifo_count),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_act = 1'b0;
        m_k   = 0;
        m_ovf = 1'b0;
        m_cur = 8'd0;
    endtask

    // Line level k cycles into a frame: start bit, 8 data bits LSB first, stop bit.
    function automatic logic exp_tx();
        if (!m_act)        return 1'b1;
        if (m_k < C)       return 1'b0;
        if (m_k < 9 * C)   return m_cur[(m_k - C) / C];
        return 1'b1;
    endfunction

    task automatic model_step(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bit pop, push, clr, accept;
        int sz;
        sz     = m_q.size();
        pop    = !m_act && (sz != 0);
        push   = we && (addr == TX_ADDR);
        clr    = we && (addr == CLR_ADDR);
        accept = push && ((sz < D) || pop);
        if (pop) m_cur = m_q.pop_front();
        if (accept) m_q.push_back(data[7:0]);
        if (push && !accept) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (pop) begin
            m_act = 1'b1;
            m_k   = 0;
        end else if (m_act) begin
            if (m_k == 10 * C - 1) m_act = 1'b0;
            else m_k++;
        end
    endtask

    task automatic compare_all();
        check_eq("tx", 32'(tx), 32'(exp_tx()));
        check_eq("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("busy", 32'(busy), 32'(m_act || (m_q.size() != 0)));
    endtask

    task automatic cycle(input logic we, input logic [31:0] addr, input logic [31:0] data);
        writting_to_mem = we;
        value_from_alu  = addr;
        data_to_write   = data;
        @(posedge clk);
        model_step(we, addr, data);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        bit found;
        reset           = 1'b1;
        writting_to_mem = 1'b0;
        value_from_alu  = 32'd0;
        data_to_write   = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        #3 reset = 1'b0;

        // Single byte, upper data bits ignored.
        cycle(1'b1, TX_ADDR, 32'hFFFF_FF55);
        idle(45);

        // Non-matching stores and a disabled cycle on the TX address.
        cycle(1'b1, 32'h0000_1008, 32'h0000_0077);
        cycle(1'b1, TX_ADDR - 32'd4, 32'h0000_0066);
        cycle(1'b0, TX_ADDR, 32'h0000_0044);
        idle(3);

        // Overflow burst, drain, clear.
        for (int i = 1; i <= 6; i++) cycle(1'b1, TX_ADDR, 32'(i));
        idle(5 * (10 * C + 1) + 5);
        cycle(1'b1, CLR_ADDR, 32'hDEAD_BEEF);

        // Overflow again, then reset during data bit 3 of the first frame.
        for (int i = 1; i <= 6; i++) cycle(1'b1, TX_ADDR, 32'(8'h30 + i));
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (m_act && m_k == 4 * C + 1) found = 1'b1;
            else cycle(1'b0, 32'd0, 32'd0);
        end
        check_eq("wait_bit3", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_tx", 32'(tx), 32'd1);
        check_eq("midrst_count", 32'(fifo_count), 32'd0);
        check_eq("midrst_overflow", 32'(overflow), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
        cycle(1'b1, TX_ADDR, 32'h0000_00C3);
        idle(45);

        // Fill FIFO, then push exactly on the IDLE pop cycle.
        for (int i = 0; i < 5; i++) cycle(1'b1, TX_ADDR, 32'(8'h11 * (i + 1)));
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (!m_act && m_q.size() == D) found = 1'b1;
            else cycle(1'b0, 32'd0, 32'd0);
        end
        check_eq("wait_pop_cycle", 32'(found), 32'd1);
        cycle(1'b1, TX_ADDR, 32'h0000_00A5);
        check_eq("simul_count", 32'(fifo_count), 32'(D));
        check_eq("simul_overflow", 32'(overflow), 32'd0);
        idle(5 * (10 * C + 1) + 5);

        // Random traffic over all address classes.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4)       cycle(1'b1, TX_ADDR, $urandom());
            else if (r < 6)  cycle(1'b1, CLR_ADDR, $urandom());
            else if (r < 8)  cycle(1'b1, TX_ADDR - 32'd4, $urandom());
            else if (r < 10) cycle(1'b1, 32'h0000_1008, $urandom());
            else if (r < 12) cycle(1'b1, $urandom(), $urandom());
            else if (r < 14) cycle(1'b0, TX_ADDR, $urandom());
            else             cycle(1'b0, 32'd0, 32'd0);
        end
        idle(6 * (10 * C + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter attached downstream of the single-cycle RV32I core's store outputs. It snoops every store cycle and captures byte writes to its TX data address into a small FIFO. It then serialises each byte as an 8N1 frame on a `tx` pin. The core cannot stall, so the block never back-pressures: overflowing stores are dropped and flagged in a sticky status bit.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (115200 baud at 100 MHz); must be ≥ 2.
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, ≥ 2.
- `TX_ADDR`, 32'h0000_1000, store address that enqueues `data_to_write[7:0]`.
- `CLR_ADDR`, 32'h0000_1004, store address that clears the overflow flag (data ignored).

Ports:
- `clk` in 1: 100 MHz clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `value_from_alu` in 32: store address from the core.
- `data_to_write` in 32: store data from the core.
- `writting_to_mem` in 1: core store-enable for the current cycle.
- `tx` out 1: UART serial line, idle high.
- `busy` out 1: high when the FIFO is non-empty or a frame is in progress.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky flag, set when a TX store was dropped.

## Operation
- **Push.** A push occurs when `writting_to_mem` is high and `value_from_alu == TX_ADDR` (full 32-bit compare) at a rising edge. The push writes `data_to_write[7:0]`; bits [31:8] are ignored.
- **Acceptance.** A push is accepted if `fifo_count < FIFO_DEPTH`, or if a pop occurs in the same cycle. A pop and push in the same cycle leave the count unchanged.
- **Drop.** A push into a full FIFO with no simultaneous pop is dropped. Dropping sets `overflow` at that edge.
- **Clear.** A store to `CLR_ADDR` clears `overflow`. If a drop and a clear occur in the same cycle, set wins.
- **Other stores.** Stores to any other address are ignored.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter and bit index, and go to START. Otherwise stay in IDLE.
  - START: drive `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: drive `shift[0]` for `CLKS_PER_BIT` cycles per bit, then shift right. After 8 bits (LSB first), go to STOP.
  - STOP: drive `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- **Baud counter.** Counts 0..`CLKS_PER_BIT`-1 and wraps. The bit index is a 3-bit counter that wraps from 7 to 0 on the DATA→STOP transition.
- **FIFO pointers.** Read and write pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Full/empty is derived from the separate count register.
- **busy** = (state != IDLE) || (fifo_count != 0). This output is combinational from registers.

## Timing
- **Reset values** (async assert, synchronous release at the next edge): state IDLE, `tx`=1, `fifo_count`=0, `overflow`=0, `busy`=0. Pointers, counters and shift register are all 0.
- **Push latency.** A push at edge N makes `fifo_count` increment after edge N. At edge N+1 the FSM pops the byte and `tx` falls, so the start bit begins one cycle after the push if the FSM was idle.
- **Frame length.** Each frame lasts exactly 10×`CLKS_PER_BIT` cycles, with one IDLE cycle between back-to-back frames. The frame period is therefore 10×`CLKS_PER_BIT`+1 cycles.
- **`tx` output.** `tx` is driven from a flop; it never glitches from comb logic.
- **Reset mid-frame.** `tx` returns high immediately, and queued bytes and `overflow` are discarded.

## Structure
- The shared package `mmio_pkg` holds the `TX_ADDR`/`CLR_ADDR` default constants and the `uart_state_t` enum (IDLE, START, DATA, STOP). It is also the home for future MMIO address constants.
- The FIFO is a separate sub-module, `sync_fifo` (parameters: width, depth). It has `push`/`pop`/`din`/`dout`/`count`/`full`/`empty` signals and the same `clk`/`reset` as this block. `dout` presents the head combinationally.
- The top of this block contains the address decode, overflow flag, FSM, baud counter and shift register.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- **Single byte.** Store 32'hFFFF_FF55 to `TX_ADDR`. `tx` goes low one cycle later, then carries bits 1,0,1,0,1,0,1,0 for 4 cycles each, then stop high. Total frame is 40 cycles; `busy` drops after STOP.
- **Non-matching stores.** Issue stores to 32'h0000_1008 and to `TX_ADDR`-4, plus a cycle with `writting_to_mem`=0 and address `TX_ADDR`. `fifo_count` stays 0, `tx` stays 1, `overflow` stays 0.
- **Overflow.** Issue 6 consecutive TX stores (0x01..0x06). 0x01 is popped at once and 0x02..0x05 fill the FIFO, so 0x06 is dropped and `overflow`=1. The frames emitted are 0x01..0x05 in order, each 41 cycles apart.
- **Clear.** With `overflow`=1, store to `CLR_ADDR`; `overflow`=0 next cycle. Then repeat the clear in the same cycle as a dropped push; `overflow` remains 1.
- **Simultaneous push and pop.** With the FIFO full and the FSM finishing STOP, push 0xA5 exactly on the IDLE pop cycle. The push is accepted, `fifo_count` is unchanged, `overflow` stays 0, and 0xA5 is the last frame sent.
- **Reset mid-frame.** Assert `reset` during DATA bit 3. `tx`=1 and `fifo_count`=0 asynchronously. After release, one new store produces a clean frame.
